// File: rtl/crc_frame_engine_pkg.sv
// crc_pkg: definitions shared by the CRC frame engine files.
//   state_t          - frame FSM states (IDLE, ACCUM, RESULT)
//   CRC32_*          - CRC-32 (IEEE 802.3) polynomial, init, xorout and the
//                      raw register value left by a frame that carries its own CRC
//   CRC16_*          - CRC-16/CCITT-FALSE polynomial, init, xorout
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_XOROUT  = 16'h0000;

endpackage

// File: rtl/crc_frame_engine_if.sv
// crc_frame_engine_if: beat input stream and result output of the CRC engine.
//   s_valid/s_ready/s_data/s_keep/s_last - input beats, byte 0 = s_data[7:0]
//   m_valid/m_ready/m_crc/m_ok           - frame result
// Modports: slave (the engine), master (the block feeding and draining it).
interface crc_frame_engine_if #(
    parameter int DATA_BYTES = 1,
    parameter int CRC_W      = 32
);
    logic                    s_valid;
    logic                    s_ready;
    logic [8*DATA_BYTES-1:0] s_data;
    logic [DATA_BYTES-1:0]   s_keep;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [CRC_W-1:0]        m_crc;
    logic                    m_ok;

    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_crc, m_ok
    );

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_crc, m_ok
    );
endinterface

// File: rtl/crc_byte_step.sv
// crc_byte_step: combinational update of an MSB-first CRC register by one byte.
//   crc_in  - register before the byte
//   data    - byte to absorb (LSB first when REFIN != 0, else MSB first)
//   crc_out - register after eight shift/conditional-XOR steps
module crc_byte_step #(
    parameter int          CRC_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter int          REFIN = 1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);
    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

    always_comb begin
        logic [CRC_W-1:0] c;
        logic             in_bit;
        logic             fb;
        // NOTE: every variable written here gets a value before any branch,
        // so no path leaves one holding its old value (that would be a latch).
        c      = crc_in;
        in_bit = 1'b0;
        fb     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_bit = (REFIN != 0) ? data[i] : data[7-i];
            fb     = c[CRC_W-1] ^ in_bit;
            c      = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
        crc_out = c;
    end
endmodule

// File: rtl/crc_frame_engine.sv
// crc_frame_engine: computes a parameterised CRC over framed byte beats.
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset; discards any partial frame
//   bus     - crc_frame_engine_if.slave: beats in (s_*), result out (m_*)
// Up to DATA_BYTES bytes are absorbed per beat; the result appears one cycle
// after the last beat and is held until m_ready.
// Build option: define CRC_FRAME_CHECK_EN to register m_ok (raw register ==
// RESIDUE); otherwise m_ok is tied low and no comparator is built.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOROUT     = CRC32_XOROUT,
    parameter int          REFIN      = 1,
    parameter int          REFOUT     = 1,
    parameter int          DATA_BYTES = 1,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_frame_engine_if.slave    bus
);
    localparam logic [CRC_W-1:0] INIT_W   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_W = XOROUT[CRC_W-1:0];

    state_t state, next_state;

    logic [CRC_W-1:0] raw;
    logic [CRC_W-1:0] m_crc_q;
    logic             live;      // low during reset and until the first clock after it
    logic             ready;
    logic             accept;

    logic [DATA_BYTES-1:0] run;  // byte k enabled and every byte below it enabled
    logic [CRC_W-1:0]      chain    [DATA_BYTES+1];
    logic [CRC_W-1:0]      step_out [DATA_BYTES];
    logic [CRC_W-1:0]      frame_raw;
    logic [CRC_W-1:0]      result_crc;

    assign ready  = live && (state != RESULT);
    assign accept = bus.s_valid && ready;

    // Bytes are enabled only as a contiguous run from byte 0; the first
    // cleared keep bit masks itself and everything above it.
    always_comb begin
        run    = '0;
        run[0] = bus.s_keep[0];
        for (int k = 1; k < DATA_BYTES; k++) begin
            run[k] = run[k-1] & bus.s_keep[k];
        end
    end

    assign chain[0] = raw;

    for (genvar k = 0; k < DATA_BYTES; k++) begin : g_step
        crc_byte_step #(
            .CRC_W (CRC_W),
            .POLY  (POLY),
            .REFIN (REFIN)
        ) u_step (
            .crc_in  (chain[k]),
            .data    (bus.s_data[8*k +: 8]),
            .crc_out (step_out[k])
        );
        assign chain[k+1] = run[k] ? step_out[k] : chain[k];
    end

    assign frame_raw = chain[DATA_BYTES];

    always_comb begin
        logic [CRC_W-1:0] refl;
        refl = '0;
        for (int i = 0; i < CRC_W; i++) begin
            refl[i] = frame_raw[CRC_W-1-i];
        end
        result_crc = ((REFOUT != 0) ? refl : frame_raw) ^ XOROUT_W;
    end

    // Frame FSM.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers are updated with <= so every flop samples the values
        // from before the edge, independent of statement order.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = bus.s_last ? RESULT : ACCUM;
            ACCUM:   if (accept && bus.s_last) next_state = RESULT;
            RESULT:  if (bus.m_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // CRC register and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw     <= INIT_W;
            m_crc_q <= '0;
            live    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                raw <= frame_raw;
                if (bus.s_last) m_crc_q <= result_crc;
            end else if (state == RESULT && bus.m_ready) begin
                raw <= INIT_W;
            end
        end
    end

`ifdef CRC_FRAME_CHECK_EN
    logic m_ok_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     m_ok_q <= 1'b0;
        else if (accept && bus.s_last) m_ok_q <= (frame_raw == RESIDUE[CRC_W-1:0]);
    end

    assign bus.m_ok = m_ok_q;
`else
    assign bus.m_ok = 1'b0;
`endif

    assign bus.s_ready = ready;
    assign bus.m_valid = (state == RESULT);
    assign bus.m_crc   = m_crc_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// tb_crc_frame_engine: directed checks of crc_frame_engine in three builds:
//   dut_a - defaults (CRC-32, 1 byte per beat)
//   dut_b - CRC-32, 4 bytes per beat
//   dut_c - CRC-16/CCITT-FALSE, 1 byte per beat
module tb_crc_frame_engine;
    import crc_pkg::*;

`ifdef CRC_FRAME_CHECK_EN
    localparam logic [31:0] OK_EN = 32'd1;
`else
    localparam logic [31:0] OK_EN = 32'd0;
`endif

    localparam logic [31:0] CRC32_CHECK = 32'hCBF43926;
    localparam logic [31:0] CRC32_MAGIC = 32'h2144DF1C;
    localparam logic [31:0] CRC16_CHECK = 32'h000029B1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [7:0] q [$];

    crc_frame_engine_if #(.DATA_BYTES(1), .CRC_W(32)) if_a ();
    crc_frame_engine_if #(.DATA_BYTES(4), .CRC_W(32)) if_b ();
    crc_frame_engine_if #(.DATA_BYTES(1), .CRC_W(16)) if_c ();

    crc_frame_engine dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));

    crc_frame_engine #(.DATA_BYTES(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    crc_frame_engine #(
        .CRC_W   (16),
        .POLY    ({16'h0, CRC16_POLY}),
        .INIT    ({16'h0, CRC16_INIT}),
        .XOROUT  ({16'h0, CRC16_XOROUT}),
        .REFIN   (0),
        .REFOUT  (0)
    ) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_crc(input int d);
        case (d)
            0:       return if_a.m_crc;
            1:       return if_b.m_crc;
            default: return {16'h0, if_c.m_crc};
        endcase
    endfunction

    function automatic logic [31:0] obs_valid(input int d);
        case (d)
            0:       return {31'h0, if_a.m_valid};
            1:       return {31'h0, if_b.m_valid};
            default: return {31'h0, if_c.m_valid};
        endcase
    endfunction

    function automatic logic [31:0] obs_ok(input int d);
        case (d)
            0:       return {31'h0, if_a.m_ok};
            1:       return {31'h0, if_b.m_ok};
            default: return {31'h0, if_c.m_ok};
        endcase
    endfunction

    function automatic logic [31:0] obs_ready(input int d);
        case (d)
            0:       return {31'h0, if_a.s_ready};
            1:       return {31'h0, if_b.s_ready};
            default: return {31'h0, if_c.s_ready};
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] data,
                         input logic [3:0] keep, input logic last);
        case (d)
            0: begin
                if_a.s_valid = v; if_a.s_data = data[7:0]; if_a.s_keep = keep[0:0]; if_a.s_last = last;
            end
            1: begin
                if_b.s_valid = v; if_b.s_data = data; if_b.s_keep = keep; if_b.s_last = last;
            end
            default: begin
                if_c.s_valid = v; if_c.s_data = data[7:0]; if_c.s_keep = keep[0:0]; if_c.s_last = last;
            end
        endcase
    endtask

    task automatic set_mready(input int d, input logic v);
        case (d)
            0:       if_a.m_ready = v;
            1:       if_b.m_ready = v;
            default: if_c.m_ready = v;
        endcase
    endtask

    // One beat, accepted on the next rising edge; no result may be showing
    // while the last beat is still on the bus.
    task automatic beat(input int d, input logic [31:0] data, input logic [3:0] keep, input logic last);
        @(negedge clk);
        drive(d, 1'b1, data, keep, last);
        if (last) check("valid_before_last", obs_valid(d), 32'd0);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic frame_q(input int d, input logic end_frame);
        for (int i = 0; i < q.size(); i++) begin
            beat(d, {24'h0, q[i]}, 4'h1, end_frame && (i == q.size() - 1));
        end
    endtask

    task automatic result(input int d, input string tag, input logic [31:0] exp_crc,
                          input logic [31:0] exp_ok, input logic chk_crc);
        @(negedge clk);
        check({tag, "_valid"}, obs_valid(d), 32'd1);
        if (chk_crc) check({tag, "_crc"}, obs_crc(d), exp_crc);
        check({tag, "_ok"}, obs_ok(d), exp_ok);
        set_mready(d, 1'b1);
        @(posedge clk);
        #1;
        set_mready(d, 1'b0);
        @(negedge clk);
        check({tag, "_valid_cleared"}, obs_valid(d), 32'd0);
        check({tag, "_ready_again"}, obs_ready(d), 32'd1);
    endtask

    task automatic load_msg();
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 32'h0, 4'h0, 1'b0);
            set_mready(d, 1'b0);
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", obs_ready(0), 32'd0);
        check("rst_valid", obs_valid(0), 32'd0);
        check("rst_crc", obs_crc(0), 32'd0);
        check("rst_ok", obs_ok(0), 32'd0);
        check("rst_ready_b", obs_ready(1), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_before_first_clk", obs_ready(0), 32'd0);
        @(negedge clk);
        check("ready_after_first_clk", obs_ready(0), 32'd1);

        // CRC-32 check value, one byte per beat.
        load_msg();
        frame_q(0, 1'b1);
        result(0, "a_check", CRC32_CHECK, 32'd0, 1'b1);

        // Result held while m_ready stays low; beats offered meanwhile are ignored.
        load_msg();
        frame_q(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 1'b1, 32'hAA, 4'h1, 1'b1);
            check("hold_valid", obs_valid(0), 32'd1);
            check("hold_crc", obs_crc(0), CRC32_CHECK);
            check("hold_ready", obs_ready(0), 32'd0);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        set_mready(0, 1'b1);
        @(posedge clk);
        #1;
        set_mready(0, 1'b0);
        @(negedge clk);
        check("hold_released", obs_valid(0), 32'd0);

        // Next frame restarts from INIT.
        load_msg();
        frame_q(0, 1'b1);
        result(0, "a_after_hold", CRC32_CHECK, 32'd0, 1'b1);

        // Frame carrying its own CRC: residue match.
        load_msg();
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        frame_q(0, 1'b1);
        result(0, "a_residue", CRC32_MAGIC, OK_EN, 1'b1);

        // Same frame with one bit flipped: no match.
        load_msg();
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        q[0] = 8'h30;
        frame_q(0, 1'b1);
        result(0, "a_bad_frame", 32'h0, 32'd0, 1'b0);

        // Reset in the middle of a frame.
        q = {8'h31, 8'h32, 8'h33, 8'h34};
        frame_q(0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", obs_ready(0), 32'd0);
        check("abort_valid", obs_valid(0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_result", obs_valid(0), 32'd0);
        check("abort_ready_back", obs_ready(0), 32'd1);
        load_msg();
        frame_q(0, 1'b1);
        result(0, "a_after_abort", CRC32_CHECK, 32'd0, 1'b1);

        // Empty frame: last beat with no bytes enabled.
        beat(0, 32'h0, 4'h0, 1'b1);
        result(0, "a_empty", 32'h0, 32'd0, 1'b1);

        // Four bytes per beat.
        beat(1, 32'h34333231, 4'hF, 1'b0);
        beat(1, 32'h38373635, 4'hF, 1'b0);
        beat(1, 32'h00000039, 4'h1, 1'b1);
        result(1, "b_check", CRC32_CHECK, 32'd0, 1'b1);

        // Bytes above the first cleared keep bit are ignored.
        beat(1, 32'h34333231, 4'hF, 1'b0);
        beat(1, 32'h38373635, 4'hF, 1'b0);
        beat(1, 32'hAABBCC39, 4'hD, 1'b1);
        result(1, "b_keep_gap", CRC32_CHECK, 32'd0, 1'b1);

        // CRC-16/CCITT-FALSE.
        load_msg();
        frame_q(2, 1'b1);
        result(2, "c_check", CRC16_CHECK, 32'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/crc_frame_engine.md
CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 32, the CRC register width (8..32).
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, the generator polynomial in normal (MSB-first) form, low CRC_W bits used.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, the register value at frame start.
REQ-004 SHALL have parameter XOROUT, default 32'hFFFFFFFF, XORed into the result.
REQ-005 SHALL have parameter REFIN, default 1; 1 = each byte fed LSB first.
REQ-006 SHALL have parameter REFOUT, default 1; 1 = register bit-reversed before XOROUT.
REQ-007 SHALL have parameter DATA_BYTES, default 1, bytes per beat (1..8).
REQ-008 SHALL have parameter RESIDUE, default 32'hC704DD7B, the good-frame raw register value.
REQ-009 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-011 SHALL have port s_valid, input, 1, input beat valid.
REQ-012 SHALL have port s_ready, output, 1, beat accepted when s_valid && s_ready.
REQ-013 SHALL have port s_data, input, 8*DATA_BYTES, beat data; byte 0 = s_data[7:0], processed first.
REQ-014 SHALL have port s_keep, input, DATA_BYTES, byte enables, contiguous from bit 0.
REQ-015 SHALL have port s_last, input, 1, final beat of the frame.
REQ-016 SHALL have port m_valid, output, 1, result valid.
REQ-017 SHALL have port m_ready, input, 1, result consumed when m_valid && m_ready.
REQ-018 SHALL have port m_crc, output, CRC_W, final CRC.
REQ-019 SHALL have port m_ok, output, 1, raw register == RESIDUE[CRC_W-1:0].

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM and RESULT.
REQ-021 SHALL transition IDLE->ACCUM on an accepted non-last beat, IDLE/ACCUM->RESULT on an accepted last beat, and RESULT->IDLE on m_valid && m_ready.
REQ-022 SHALL drive s_ready = 1 in IDLE and ACCUM and 0 in RESULT.
REQ-023 SHALL start each frame from INIT, with the raw register kept MSB-first, shifting left and conditionally XORing POLY once per input bit.
REQ-024 SHALL process the enabled bytes of a beat (up to the first 0 in s_keep) in a single cycle; bytes above the first 0 are ignored.
REQ-025 SHALL treat a last beat with s_keep = 0 as ending the frame with no data.
REQ-026 SHALL assert m_valid in the cycle after the last beat is accepted (1-cycle latency).
REQ-027 SHALL form m_crc as (REFOUT ? bitreverse(raw) : raw) ^ XOROUT.
REQ-028 SHALL hold m_crc and m_ok stable while m_valid && !m_ready.
REQ-029 SHALL reload the raw register with INIT when RESULT->IDLE.
REQ-030 SHALL ignore beats while s_ready = 0, with no state change.

Reset
REQ-031 SHALL, on asserted reset at any time including mid-frame, set state IDLE, raw register = INIT, m_valid = 0, m_crc = 0, m_ok = 0, s_ready = 0 while asserted, and s_ready = 1 from the first clock after release.
REQ-032 SHALL discard a partial frame on reset and emit no result for it.

Configuration
REQ-033 SHALL use macro CRC_FRAME_CHECK_EN: when defined, m_ok is registered with m_crc per REQ-019; when undefined, m_ok is constant 0 and the comparator is absent.

Structure
REQ-034 SHALL place in shared package crc_pkg: the FSM state typedef, the CRC-32 constants (POLY/INIT/XOROUT/RESIDUE) and the CRC-16/CCITT-FALSE constants (16'h1021, 16'hFFFF, 16'h0000).
REQ-035 SHALL use a single combinational sub-module, crc_byte_step (CRC_W, POLY, REFIN), that updates the register by one byte, instantiated DATA_BYTES times and chained with keep-gated bypass.

Verification
REQ-036 SHALL verify: defaults, DATA_BYTES=1, bytes "123456789" (0x31..0x39), last on 0x39 -> m_crc = 32'hCBF43926 one cycle after the last beat.
REQ-037 SHALL verify: DATA_BYTES=4, beats 32'h34333231/keep 4'hF, 32'h38373635/keep 4'hF, 32'h00000039/keep 4'h1/last -> m_crc = 32'hCBF43926.
REQ-038 SHALL verify: CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOROUT=0, REFIN=REFOUT=0, "123456789" -> m_crc = 16'h29B1.
REQ-039 SHALL verify: CRC_FRAME_CHECK_EN defined, defaults, "123456789" then 0x26 0x39 0xF4 0xCB -> m_ok = 1; the same frame with one bit flipped -> m_ok = 0.
REQ-040 SHALL verify: m_ready held low for 3 cycles after m_valid -> m_valid, m_crc stable and s_ready = 0; a following frame is computed from INIT.
REQ-041 SHALL verify: reset pulsed after 4 bytes of a frame, then "123456789" -> no result for the aborted frame and 32'hCBF43926 for the new one; a single last beat with keep = 0 -> m_crc = 32'h00000000.
